// File: rtl/yarb_pkg.sv
// yarb_pkg: shared arbitration-mode encodings and width helper for the yarb_mux slice
package yarb_pkg;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/yarb_mux_if.sv
// yarb_mux_if: N-channel valid/ready ingress plus single registered egress
interface yarb_mux_if import yarb_pkg::*; #(
    parameter int N = 4,
    parameter int W = 8
) ();
    localparam int SELW = clog2(N);
    logic              mode;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_sel;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/yarb_pick.sv
// yarb_pick: rotating-start priority search; fixed mode always starts at channel 0
module yarb_pick import yarb_pkg::*; #(
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    input  logic            mode,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);
    logic [SELW-1:0] base;
    logic [SELW-1:0] idx;

    always_comb begin
        base = (mode == MODE_FIXED) ? '0 : start;
        gnt_valid = |req;
        gnt_idx = '0;
        idx = '0;
        // Descending offsets so the nearest requester to base is written last
        for (int k = N - 1; k >= 0; k--) begin
            idx = SELW'((int'(base) + k) % N);
            if (req[idx]) gnt_idx = idx;
        end
    end
endmodule

// File: rtl/yarb_mux.sv
// yarb_mux: N:1 arbitrated stream mux with one registered output stage
module yarb_mux import yarb_pkg::*; #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic clk,
    input logic reset,
    yarb_mux_if.slave bus
);
    localparam int SELW = clog2(N);

    logic            outValid;
    logic [W-1:0]    outData;
    logic [SELW-1:0] outSel;
    logic [SELW-1:0] ptr;
    logic            load;
    logic            take;
    logic            gntValid;
    logic [SELW-1:0] gntIdx;

    yarb_pick #(.N(N), .SELW(SELW)) pick (
        .req(bus.in_valid),
        .start(ptr),
        .mode(bus.mode),
        .gnt_valid(gntValid),
        .gnt_idx(gntIdx)
    );

    assign load = !outValid || bus.out_ready;
    assign take = load && gntValid && !reset;
    assign bus.in_ready = take ? (N'(1) << gntIdx) : '0;
    assign bus.out_valid = outValid;
    assign bus.out_data = outData;
    assign bus.out_sel = outSel;

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid <= 1'b0;
            outData <= '0;
            outSel <= '0;
            ptr <= '0;
        end else if (take) begin
            outValid <= 1'b1;
            outData <= bus.in_data[gntIdx * W +: W];
            outSel <= gntIdx;
            if (bus.mode == MODE_RR) ptr <= (int'(gntIdx) == N - 1) ? '0 : gntIdx + SELW'(1);
        end else if (bus.out_ready) begin
            outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_yarb_mux.sv
// tb_yarb_mux: directed plan scenarios plus randomized traffic against a behavioural arbiter model
module tb_yarb_mux;
    import yarb_pkg::*;
    localparam int N = 4;
    localparam int W = 8;
    localparam int SELW = clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b1;
    yarb_mux_if #(.N(N), .W(W)) bus();
    yarb_mux #(.N(N), .W(W)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int mPtr = 0;
    int mSel = 0;
    int g;
    logic mValid = 1'b0;
    logic [W-1:0] mData = '0;
    logic [N-1:0] expReady, obsReady;

    function automatic int arbitrate(input logic [N-1:0] v, input logic m, input int p);
        int s;
        s = (m == MODE_FIXED) ? 0 : p;
        for (int i = 0; i < N; i++) if (v[(s + i) % N]) return (s + i) % N;
        return -1;
    endfunction

    task automatic setData(input logic [W-1:0] b);
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = b + W'(i);
    endtask

    task automatic step();
        @(negedge clk);
        g = (reset || (mValid && !bus.out_ready)) ? -1 : arbitrate(bus.in_valid, bus.mode, mPtr);
        expReady = (g < 0) ? '0 : N'(1) << g;
        obsReady = bus.in_ready;
        @(posedge clk);
        if (reset) begin
            mValid = 1'b0; mData = '0; mSel = 0; mPtr = 0;
        end else if (g >= 0) begin
            mValid = 1'b1; mData = bus.in_data[g*W +: W]; mSel = g;
            if (bus.mode == MODE_RR) mPtr = (g + 1) % N;
        end else if (bus.out_ready) begin
            mValid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mode = MODE_RR; bus.out_ready = 1'b1; bus.in_valid = 4'b1111; setData(8'hA0);
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (obsReady !== 4'b0000 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, want 0000 0 00", i, obsReady, bus.out_valid, bus.out_data);
            end
        end
        reset = 1'b0;
        step();
        vectors++;
        if (obsReady !== 4'b0001 || bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: in_ready=%b sel=%0d data=%h valid=%b, want 0001 0 a0 1", obsReady, bus.out_sel, bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1; step(); reset = 1'b0;
        bus.mode = MODE_RR; bus.out_ready = 1'b1; bus.in_valid = 4'b1111; setData(8'hA0);
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== SELW'(i % N) || bus.out_data !== 8'hA0 + W'(i % N)
                || obsReady !== expReady || bus.out_data !== mData) begin
                errors++;
                $display("FAIL rr[%0d]: valid=%b sel=%0d data=%h ready=%b, want 1 %0d %h %b", i, bus.out_valid, bus.out_sel, bus.out_data, obsReady, i % N, 8'hA0 + W'(i % N), expReady);
            end
        end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obsReady !== 4'b0000 || bus.out_data !== 8'hA1 || bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1) begin
                errors++;
                $display("FAIL stall[%0d]: ready=%b data=%h valid=%b sel=%0d, want 0000 a1 1 1", i, obsReady, bus.out_data, bus.out_valid, bus.out_sel);
            end
        end
        bus.out_ready = 1'b1;
        step();
        vectors++;
        if (bus.out_data !== 8'hA2 || bus.out_sel !== 2'd2 || obsReady !== 4'b0100) begin
            errors++;
            $display("FAIL stall_resume: data=%h sel=%0d ready=%b, want a2 2 0100", bus.out_data, bus.out_sel, obsReady);
        end
    endtask

    task automatic test_fixed();
        reset = 1'b1; step(); reset = 1'b0;
        bus.mode = MODE_FIXED; bus.out_ready = 1'b1; bus.in_valid = 4'b1111; setData(8'hA0);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0 || obsReady !== 4'b0001) begin
                errors++;
                $display("FAIL fixed[%0d]: sel=%0d data=%h ready=%b, want 0 a0 0001", i, bus.out_sel, bus.out_data, obsReady);
            end
        end
        bus.in_valid = 4'b1110;
        step();
        vectors++;
        if (bus.out_sel !== 2'd1 || obsReady !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_1110: sel=%0d ready=%b, want 1 0010", bus.out_sel, obsReady);
        end
        bus.mode = MODE_RR;
        step();
        vectors++;
        if (bus.out_sel !== 2'd1 || bus.out_data !== 8'hA1 || obsReady !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_to_rr: sel=%0d data=%h ready=%b, want 1 a1 0010", bus.out_sel, bus.out_data, obsReady);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; step(); reset = 1'b0;
        bus.mode = MODE_RR; bus.out_ready = 1'b1; bus.in_valid = 4'b0100; setData(8'hA0);
        step();
        bus.in_data[2*W +: W] = 8'h5C;
        step();
        vectors++;
        if (obsReady !== 4'b0100 || bus.out_data !== 8'h5C || bus.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL wrap: ready=%b data=%h sel=%0d, want 0100 5c 2", obsReady, bus.out_data, bus.out_sel);
        end
        bus.in_valid = 4'b1111;
        step();
        vectors++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 8'hA3) begin
            errors++;
            $display("FAIL wrap_ptr: sel=%0d data=%h, want 3 a3", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h00 || obsReady !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stall: valid=%b sel=%0d data=%h ready=%b, want 0 0 00 0000", bus.out_valid, bus.out_sel, bus.out_data, obsReady);
        end
        reset = 1'b0; bus.in_valid = 4'b0000; bus.out_ready = 1'b1;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_replay: valid=%b, want 0", bus.out_valid);
        end
        bus.in_valid = 4'b1111;
        step();
        vectors++;
        if (bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ptr: sel=%0d valid=%b, want 0 1", bus.out_sel, bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        pend = '0;
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        step();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    bus.in_data[i*W +: W] = W'($urandom);
                end
            end
            bus.in_valid = pend;
            step();
            vectors++;
            if (obsReady !== expReady || bus.out_valid !== mValid || bus.out_data !== mData || bus.out_sel !== SELW'(mSel)) begin
                errors++;
                $display("FAIL random[%0d]: ready=%b/%b valid=%b/%b data=%h/%h sel=%0d/%0d (got/want)",
                         n, obsReady, expReady, bus.out_valid, mValid, bus.out_data, mData, bus.out_sel, mSel);
            end
            pend &= ~expReady;
        end
    endtask

    initial begin
        bus.mode = MODE_RR;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_stall();
        test_fixed();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/yarb_mux.md
Name: yarb_mux

Overview:
- Parametrised N-input, W-bit stream multiplexer with one registered output stage and a valid/ready handshake on every port.
- Successor to the 2:1 combinational yMux family. Adds:
  - N channels instead of two.
  - Arbitration: round-robin or fixed priority, instead of an external select.
  - Backpressure and a one-cycle registered latency.
- Sits between several producer stages and one shared consumer, for example a shared datapath or bus port.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel; minimum 1.
- SELW, clog2(N), width of the channel index; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle.
- in_valid  in  N  per-channel request; bit i belongs to channel i.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
- in_ready  out  N  per-channel accept; one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  W  registered data word.
- out_sel  out  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (reset=1 at a clock edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - While reset=1, in_ready=0 combinationally, so no transfer occurs.
  - A reset arriving mid-stall drops the held word; it is not replayed.
- Load enable: load = !out_valid || out_ready.
  - in_ready depends combinationally on out_ready, in_valid, mode and ptr.
  - in_ready never depends on in_data.
- Grant (combinational):
  - If load=1 and in_valid != 0, exactly one channel g is granted and in_ready[g]=1.
  - Otherwise in_ready=0.
- Round-robin (mode=0):
  - Search starts at ptr, ascends, and wraps at N-1 to 0.
  - g is the first channel with in_valid set.
  - On transfer, ptr <= (g+1) mod N; the wrap from N-1 gives 0.
- Fixed priority (mode=1):
  - g is the lowest set index of in_valid.
  - ptr is not updated.
  - A switch from mode=1 back to mode=0 resumes from the retained ptr.
- Transfer on channel g at edge t (in_valid[g] && in_ready[g]):
  - At t+1: out_data = channel g data, out_sel = g, out_valid = 1.
  - Latency is exactly 1 cycle.
  - Throughput is one word per cycle while out_ready=1.
- Output drain with no new request:
  - Condition: out_valid && out_ready && in_valid==0.
  - Next cycle out_valid=0; out_data and out_sel hold their last value.
- Stall (out_valid && !out_ready):
  - out_data, out_sel, out_valid and ptr hold.
  - in_ready=0.
- Simultaneous drain and load: when out_ready=1 and a request is present, the register is replaced in the same edge with no bubble.
- Producer rule (bench checks, RTL does not enforce): once in_valid[i] is raised it stays high with stable data until in_ready[i].
- out_valid never rises without a completed transfer.

Decomposition:
- Shared package yarb_pkg:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - clog2 function used to derive SELW.
- One combinational sub-module, yarb_pick (N, SELW):
  - Inputs: req[N], start[SELW], mode.
  - Outputs: gnt_valid, gnt_idx[SELW].
  - Implements the rotating-start priority search.
  - The top level holds ptr and the output register and computes the handshakes.

Test Plan (N=4, W=8, channel i data = 8'hA0+i unless stated):
1. Reset for 2 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_data=8'h00 throughout; first grant after release goes to channel 0.
2. mode=0, all valid, out_ready=1 continuously -> out_sel sequence 0,1,2,3,0,1; out_data A0,A1,A2,A3,A0,A1; one word per cycle with no gaps.
3. After the word A1 appears, hold out_ready=0 for 3 cycles -> out_data=A1 and in_ready=0000 held for all 3 cycles; after out_ready returns to 1, next word is A2 (ptr preserved).
4. mode=1, in_valid=4'b1111 -> out_sel=0 every cycle; then in_valid=4'b1110 -> out_sel=1; then mode=0 -> grants resume from ptr=0, so out_sel=1 is granted next.
5. mode=0, ptr=3, only channel 2 valid (data 8'h5C) -> in_ready=0100, search wraps 3->0->1->2; out_data=8'h5C, out_sel=2, ptr becomes 3.
6. Stalled with out_valid=1 and out_ready=0, then assert reset for 1 cycle -> next cycle out_valid=0, out_sel=0, ptr=0; the held word is never delivered.
